psum_collector: RTL and testbench
=================================

PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of ofmap pixel accumulators held (one ofmap row of one PE column).
REQ-002 SHALL have parameter COL_IDX, default 0: index of the PE column served.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mode  input  OP_MODE  requested layer mode.
REQ-006 SHALL have port change_mode  input  1  latches mode, row_len and num_pass; aborts any operation.
REQ-007 SHALL have port row_len  input  $clog2(DEPTH)+1  pixels per pass, legal range 1..DEPTH.
REQ-008 SHALL have port num_pass  input  4  accumulation passes (input channels) per result, legal range 1..15.
REQ-009 SHALL have port op_stage  input  OP_STAGE  global stage; CONV enables accumulation.
REQ-010 SHALL have port psum_in  input  PSUM_DATA_SIZE  signed partial sum from the bottom PE of the column.
REQ-011 SHALL have port psum_valid_in  input  1  psum_in is valid.
REQ-012 SHALL have port psum_ack_out  output  1  psum_in accepted this cycle; drives the PE's psum_ack_in.
REQ-013 SHALL have port ofmap_out  output  PSUM_DATA_SIZE  final ofmap pixel.
REQ-014 SHALL have port ofmap_valid  output  1  ofmap_out valid.
REQ-015 SHALL have port ofmap_ready  input  1  output buffer takes ofmap_out.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, DRAIN.
REQ-018 IDLE -> ACCUM SHALL occur on the first cycle op_stage==CONV; wr_ptr=0, pass_cnt=0 on entry.
REQ-019 In ACCUM, psum_ack_out SHALL equal psum_valid_in, combinationally in the same cycle; it SHALL be 0 in IDLE and DRAIN (backpressure).
REQ-020 Accepted psum SHALL be written to acc[wr_ptr] on pass 0 and added to acc[wr_ptr] on later passes.
REQ-021 Addition SHALL be signed and saturate to the PSUM_DATA_SIZE maximum/minimum; no wrap.
REQ-022 wr_ptr SHALL increment per accepted psum and wrap from row_len-1 to 0, incrementing pass_cnt.
REQ-023 Acceptance at wr_ptr==row_len-1 and pass_cnt==num_pass-1 SHALL move FSM to DRAIN the next cycle, rd_ptr=0.
REQ-024 In DRAIN, ofmap_valid SHALL be 1 and ofmap_out=acc[rd_ptr], registered; first ofmap_valid one cycle after the final accepted psum.
REQ-025 ofmap_out SHALL remain stable while ofmap_valid && !ofmap_ready; rd_ptr advances only on valid&&ready.
REQ-026 Transfer at rd_ptr==row_len-1 SHALL return FSM to IDLE next cycle with ofmap_valid=0.
REQ-027 change_mode SHALL have priority over all transitions: FSM->IDLE, pointers and pass_cnt cleared, pending results discarded, ofmap_valid=0 next cycle.
REQ-028 op_stage leaving CONV during ACCUM SHALL hold state and contents (pause, no acceptance).
REQ-029 num_pass==1 SHALL give direct write-through: results equal inputs.

Reset
REQ-030 rst SHALL asynchronously force FSM=IDLE, wr_ptr=rd_ptr=pass_cnt=0, acc contents=0, psum_ack_out=0, ofmap_valid=0, ofmap_out=0, busy=0, latched mode=MODE1, row_len=DEPTH, num_pass=1.
REQ-031 rst asserted mid-ACCUM or mid-DRAIN SHALL discard all data; no partial output after release.

Configuration
REQ-032 With macro PSUM_COLLECTOR_RELU_EN defined, ofmap_out SHALL be max(acc,0) (negative results output as 0).
REQ-033 Without PSUM_COLLECTOR_RELU_EN, ofmap_out SHALL be the raw saturated signed accumulator value.

Structure
REQ-034 OP_MODE, OP_STAGE, PSUM_DATA_SIZE and saturation min/max constants SHALL come from the shared package; no local redefinition.
REQ-035 The saturating signed adder SHALL be a sub-module named psum_sat_add.

Verification
REQ-036 row_len=4, num_pass=3, psums 1..12 in order -> ofmap 15,18,21,24, first valid one cycle after 12th ack.
REQ-037 ofmap_ready low 3 cycles during DRAIN -> ofmap_out held, no loss or duplicate; psum_ack_out stays 0 throughout.
REQ-038 num_pass=2, psums of max value at one pixel -> output saturates at max; -5 result -> 0 with RELU_EN, -5 without.
REQ-039 change_mode pulsed after 6 of 8 psums -> IDLE next cycle, no ofmap_valid; fresh run produces only new data.
REQ-040 rst asserted mid-DRAIN -> outputs 0 immediately (asynchronous); after release busy=0, ofmap_valid=0.
REQ-041 op_stage leaves CONV for 5 cycles mid-pass with psum_valid_in=1 -> no acks; resume yields correct sums.

Source files
------------

// File: rtl/psum_collector_pkg.sv
// Shared types and constants for the partial-sum collector: layer modes, global stages,
// psum width with its saturation bounds, and the FSM state encoding.
package psum_collector_pkg;

  localparam int PSUM_DATA_SIZE = 16;
  localparam logic [PSUM_DATA_SIZE-1:0] PSUM_MAX = {1'b0, {(PSUM_DATA_SIZE-1){1'b1}}};
  localparam logic [PSUM_DATA_SIZE-1:0] PSUM_MIN = {1'b1, {(PSUM_DATA_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {MODE1, MODE2, MODE3} OP_MODE;
  typedef enum logic [1:0] {STG_IDLE, STG_LOAD, CONV, STG_DONE} OP_STAGE;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} collector_state_t;

  function automatic logic [PSUM_DATA_SIZE-1:0] relu(input logic [PSUM_DATA_SIZE-1:0] v);
    return v[PSUM_DATA_SIZE-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// Signed adder clamped to the psum range; purely combinational, no backpressure.
module psum_sat_add
  import psum_collector_pkg::*;
(
  input  logic [PSUM_DATA_SIZE-1:0] a,
  input  logic [PSUM_DATA_SIZE-1:0] b,
  output logic [PSUM_DATA_SIZE-1:0] sum
);

  logic [PSUM_DATA_SIZE:0] full;

  assign full = {a[PSUM_DATA_SIZE-1], a} + {b[PSUM_DATA_SIZE-1], b};

  // Top two bits disagree only on signed overflow; the extra bit gives the true sign.
  always_comb begin
    sum = full[PSUM_DATA_SIZE-1:0];
    if (full[PSUM_DATA_SIZE] != full[PSUM_DATA_SIZE-1])
      sum = full[PSUM_DATA_SIZE] ? PSUM_MIN : PSUM_MAX;
  end

endmodule

// File: rtl/psum_collector.sv
// Accumulates one ofmap row over num_pass passes, then drains it; ack is same-cycle, drain obeys ofmap_ready.
// Define PSUM_COLLECTOR_RELU_EN to clamp negative results to zero on output.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int COL_IDX = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  OP_MODE                    mode,
  input  logic                      change_mode,
  input  logic [$clog2(DEPTH):0]    row_len,
  input  logic [3:0]                num_pass,
  input  OP_STAGE                   op_stage,
  input  logic [PSUM_DATA_SIZE-1:0] psum_in,
  input  logic                      psum_valid_in,
  output logic                      psum_ack_out,
  output logic [PSUM_DATA_SIZE-1:0] ofmap_out,
  output logic                      ofmap_valid,
  input  logic                      ofmap_ready,
  output logic                      busy
);

  localparam int AW = $clog2(DEPTH);

  collector_state_t state_q, state_d;

  OP_MODE                    mode_q;
  logic [AW:0]               row_len_q;
  logic [3:0]                num_pass_q;
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [3:0]                pass_cnt;
  logic [PSUM_DATA_SIZE-1:0] acc [DEPTH];
  logic [PSUM_DATA_SIZE-1:0] sum_sat;
  logic                      last_px, last_pass, last_rd, accept;
  logic                      unused_cfg;

  // Latched mode and column index are carried for the surrounding array, not used here.
  assign unused_cfg = ^{mode_q, 1'(COL_IDX)};

  assign last_px   = ({1'b0, wr_ptr} == row_len_q - 1'b1);
  assign last_rd   = ({1'b0, rd_ptr} == row_len_q - 1'b1);
  assign last_pass = (pass_cnt == num_pass_q - 4'd1);
  assign accept    = psum_ack_out;

  psum_sat_add u_sat_add (
    .a   (acc[wr_ptr]),
    .b   (psum_in),
    .sum (sum_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    psum_ack_out = 1'b0;
    case (state_q)
      IDLE:  if (op_stage == CONV) state_d = ACCUM;
      ACCUM: begin
        psum_ack_out = psum_valid_in && (op_stage == CONV);
        if (psum_ack_out && last_px && last_pass) state_d = DRAIN;
      end
      DRAIN: if (ofmap_ready && last_rd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (change_mode) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE1;
      row_len_q  <= (AW+1)'(DEPTH);
      num_pass_q <= 4'd1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pass_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else if (change_mode) begin
      mode_q     <= mode;
      row_len_q  <= row_len;
      num_pass_q <= num_pass;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pass_cnt   <= '0;
    end else begin
      case (state_q)
        IDLE: if (op_stage == CONV) begin
          wr_ptr   <= '0;
          pass_cnt <= '0;
        end
        ACCUM: if (accept) begin
          acc[wr_ptr] <= (pass_cnt == 4'd0) ? psum_in : sum_sat;
          if (last_px) begin
            wr_ptr   <= '0;
            pass_cnt <= last_pass ? 4'd0 : pass_cnt + 4'd1;
            if (last_pass) rd_ptr <= '0;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
          end
        end
        DRAIN: if (ofmap_ready) rd_ptr <= last_rd ? '0 : rd_ptr + 1'b1;
        default: ;
      endcase
    end
  end

  // Output is a mux of registered state, so it is glitch-free and holds while stalled.
  assign ofmap_valid = (state_q == DRAIN);
  assign busy        = (state_q != IDLE);
`ifdef PSUM_COLLECTOR_RELU_EN
  assign ofmap_out   = ofmap_valid ? relu(acc[rd_ptr]) : '0;
`else
  assign ofmap_out   = ofmap_valid ? acc[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector with an arithmetic reference model and an ofmap scoreboard.
module tb_psum_collector;
  import psum_collector_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  OP_MODE                    mode;
  logic                      change_mode;
  logic [4:0]                row_len;
  logic [3:0]                num_pass;
  OP_STAGE                   op_stage;
  logic [PSUM_DATA_SIZE-1:0] psum_in;
  logic                      psum_valid_in;
  logic                      psum_ack_out;
  logic [PSUM_DATA_SIZE-1:0] ofmap_out;
  logic                      ofmap_valid;
  logic                      ofmap_ready;
  logic                      busy;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int stim[$];

  psum_collector #(.DEPTH(16), .COL_IDX(0)) dut (
    .clk(clk), .rst(rst), .mode(mode), .change_mode(change_mode),
    .row_len(row_len), .num_pass(num_pass), .op_stage(op_stage),
    .psum_in(psum_in), .psum_valid_in(psum_valid_in), .psum_ack_out(psum_ack_out),
    .ofmap_out(ofmap_out), .ofmap_valid(ofmap_valid), .ofmap_ready(ofmap_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Reference: fold stim into per-pixel sums, pass by pass, and queue the expected pixels.
  task automatic model_run(input int rl, input int np);
    int acc[16];
    int v;
    for (int p = 0; p < np; p++)
      for (int i = 0; i < rl; i++)
        acc[i] = (p == 0) ? stim[p*rl+i] : sat(acc[i] + stim[p*rl+i]);
    for (int i = 0; i < rl; i++) begin
      v = acc[i];
`ifdef PSUM_COLLECTOR_RELU_EN
      if (v < 0) v = 0;
`endif
      exp_q.push_back(v);
    end
  endtask

  function automatic int relu_exp(input int v);
`ifdef PSUM_COLLECTOR_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic send(input int v);
    int n = 0;
    psum_in       = PSUM_DATA_SIZE'(v);
    psum_valid_in = 1'b1;
    @(negedge clk);
    while (!psum_ack_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ack_timeout", n, 0);
    @(posedge clk);
    #1 psum_valid_in = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send(stim[i]);
  endtask

  task automatic set_mode(input int rl, input int np);
    @(posedge clk);
    #1;
    change_mode = 1'b1;
    row_len     = 5'(rl);
    num_pass    = 4'(np);
    @(posedge clk);
    #1 change_mode = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || ofmap_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 200, 1);
  endtask

  // Scoreboard: every valid cycle must show the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && ofmap_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ofmap", int'($signed(ofmap_out)), 99999);
      end else begin
        chk("ofmap_out", int'($signed(ofmap_out)), exp_q[0]);
        if (ofmap_ready) void'(exp_q.pop_front());
      end
      chk("ack_during_drain", psum_ack_out, 0);
    end
  end

  initial begin
    rst = 1'b1; mode = MODE1; change_mode = 1'b0; row_len = 5'd16; num_pass = 4'd1;
    op_stage = STG_IDLE; psum_in = '0; psum_valid_in = 1'b1; ofmap_ready = 1'b1;
    #23 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", ofmap_valid, 0);
    chk("reset_ofmap", int'(ofmap_out), 0);
    chk("reset_ack", psum_ack_out, 0);
    psum_valid_in = 1'b0;

    // Reset defaults: 16 pixels, single pass, write-through.
    stim = {};
    for (int i = 0; i < 16; i++) stim.push_back(i*7 - 50);
    model_run(16, 1);
    chk("model_wt_px0", exp_q[0], relu_exp(-50));
    op_stage = CONV;
    send_range(0, 16);
    wait_drain();

    // 4 pixels x 3 passes of 1..12, with a 3-cycle stall on the second pixel.
    stim = {1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    set_mode(4, 3);
    model_run(4, 3);
    chk("model_px0", exp_q[0], 15);
    chk("model_px1", exp_q[1], 18);
    chk("model_px2", exp_q[2], 21);
    chk("model_px3", exp_q[3], 24);
    send_range(0, 12);
    @(negedge clk);
    chk("first_valid_latency", ofmap_valid, 1);
    @(posedge clk);
    #1 ofmap_ready = 1'b0; psum_valid_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold", int'($signed(ofmap_out)), 18);
      chk("stall_valid", ofmap_valid, 1);
      chk("stall_ack", psum_ack_out, 0);
    end
    ofmap_ready = 1'b1; psum_valid_in = 1'b0;
    wait_drain();

    // Saturation at max and a negative result.
    stim = {32767, -3, 32767, -2};
    set_mode(2, 2);
    model_run(2, 2);
    chk("model_sat_max", exp_q[0], 32767);
    chk("model_neg5", exp_q[1], relu_exp(-5));
    send_range(0, 4);
    wait_drain();

    // Saturation at min, then recovery by addition.
    stim = {-32768, -32768, 100};
    set_mode(1, 3);
    model_run(1, 3);
    chk("model_sat_min", exp_q[0], relu_exp(-32668));
    send_range(0, 3);
    wait_drain();

    // Abort after 6 of 8 psums; the following run must carry only new data.
    stim = {1000, 1000, 1000, 1000, 1000, 1000};
    set_mode(4, 2);
    send_range(0, 6);
    set_mode(4, 2);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", ofmap_valid, 0);
    stim = {100, 101, 102, 103, 104, 105, 106, 107};
    model_run(4, 2);
    chk("model_fresh_px0", exp_q[0], 204);
    send_range(0, 8);
    wait_drain();

    // Pause mid-pass with valid held high.
    stim = {10, 20, 30, 40, 50, 60, 70, 80};
    set_mode(4, 2);
    model_run(4, 2);
    chk("model_pause_px3", exp_q[3], 120);
    send_range(0, 2);
    op_stage = STG_LOAD; psum_in = PSUM_DATA_SIZE'(30); psum_valid_in = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("pause_ack", psum_ack_out, 0);
      chk("pause_busy", busy, 1);
    end
    @(posedge clk);
    #1 op_stage = CONV;
    send_range(2, 8);
    wait_drain();

    // Asynchronous reset while draining.
    stim = {1, 2, 3, 4};
    set_mode(4, 1);
    ofmap_ready = 1'b0;
    model_run(4, 1);
    send_range(0, 4);
    @(negedge clk);
    chk("pre_reset_valid", ofmap_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", ofmap_valid, 0);
    chk("async_rst_ofmap", int'(ofmap_out), 0);
    chk("async_rst_busy", busy, 0);
    exp_q.delete();
    op_stage = STG_IDLE; ofmap_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_valid", ofmap_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
